univ_shift_reg: RTL and testbench

// - Parametrised universal register for the MAC datapath: hold, shift right, shift left, parallel load.
// - Supersedes the fixed-width parallel-in/parallel-out operand register.
// - Also acts as PISO/SIPO/SISO, using a shift counter with busy/done status for serialised operand transfer.
// - Sits between the operand source and the MAC multiplier/accumulator.

---
 rtl/univ_shift_reg.sv | 88 ++++++++
 tb/tb_univ_shift_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal hold/shift/load register with a serialisation counter and busy/done status.
// Define USR_ROTATE_EN to let rot=1 recirculate the outgoing bit instead of SIN.
module univ_shift_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] RIN,
  input  logic             SIN,
  input  logic             rot,
  output logic [WIDTH-1:0] ROUT,
  output logic             SOUT,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } mode_e;

  mode_e            op;
  logic [CNT_W-1:0] cnt;
  logic             last_dir;
  logic             in_r;
  logic             in_l;

  assign op = mode_e'(mode);

`ifdef USR_ROTATE_EN
  assign in_r = rot ? ROUT[0]       : SIN;
  assign in_l = rot ? ROUT[WIDTH-1] : SIN;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign in_r = SIN;
  assign in_l = SIN;
`endif

  // Any shift, in either direction, consumes one count; done marks the 1 -> 0 step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ROUT     <= '0;
      cnt      <= '0;
      last_dir <= 1'b0;
      done     <= 1'b0;
    end else if (!en) begin
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (op)
        HOLD: ;
        SHR: begin
          ROUT     <= {in_r, ROUT[WIDTH-1:1]};
          last_dir <= 1'b0;
          if (cnt != '0) begin
            cnt  <= cnt - CNT_ONE;
            done <= (cnt == CNT_ONE);
          end
        end
        SHL: begin
          ROUT     <= {ROUT[WIDTH-2:0], in_l};
          last_dir <= 1'b1;
          if (cnt != '0) begin
            cnt  <= cnt - CNT_ONE;
            done <= (cnt == CNT_ONE);
          end
        end
        LOAD: begin
          ROUT <= RIN;
          cnt  <= CNT_LOAD;
        end
      endcase
    end
  end

  assign SOUT = last_dir ? ROUT[WIDTH-1] : ROUT[0];
  assign busy = (cnt != '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: three widths (6, 2, 16) driven in lockstep against an arithmetic model.
module tb_univ_shift_reg;

`ifdef USR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        sin = 1'b0;
  logic        rot = 1'b0;
  logic [5:0]  rin6 = '0;
  logic [1:0]  rin2 = '0;
  logic [15:0] rin16 = '0;
  logic [5:0]  rout6;
  logic [1:0]  rout2;
  logic [15:0] rout16;
  logic        sout6, sout2, sout16;
  logic        busy6, busy2, busy16;
  logic        done6, done2, done16;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(6)) u6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .RIN(rin6), .SIN(sin), .rot(rot),
    .ROUT(rout6), .SOUT(sout6), .busy(busy6), .done(done6));
  univ_shift_reg #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .RIN(rin2), .SIN(sin), .rot(rot),
    .ROUT(rout2), .SOUT(sout2), .busy(busy2), .done(done2));
  univ_shift_reg #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .RIN(rin16), .SIN(sin), .rot(rot),
    .ROUT(rout16), .SOUT(sout16), .busy(busy16), .done(done16));

  // Model: register value as an integer, remaining-shift count, direction flag, done flag.
  int          wd[3] = '{6, 2, 16};
  int unsigned m_reg[3];
  int          m_cnt[3];
  bit          m_dir[3];
  bit          m_done[3];

  function automatic int unsigned mask_of(int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned rin_of(int i);
    case (i)
      0:       return 32'(rin6);
      1:       return 32'(rin2);
      default: return 32'(rin16);
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_reg[i] = 0; m_cnt[i] = 0; m_dir[i] = 0; m_done[i] = 0;
      end else if (!en || mode == 2'b00) begin
        m_done[i] = 0;
      end else if (mode == 2'b11) begin
        m_reg[i] = rin_of(i) & mask_of(wd[i]);
        m_cnt[i] = wd[i];
        m_done[i] = 0;
      end else begin
        int unsigned b;
        b = sin;
        if (ROT && rot)
          b = (mode == 2'b01) ? (m_reg[i] & 1) : ((m_reg[i] >> (wd[i] - 1)) & 1);
        if (mode == 2'b01) begin
          m_reg[i] = (m_reg[i] >> 1) | (b << (wd[i] - 1));
          m_dir[i] = 0;
        end else begin
          m_reg[i] = ((m_reg[i] << 1) | b) & mask_of(wd[i]);
          m_dir[i] = 1;
        end
        m_done[i] = (m_cnt[i] == 1);
        if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Every-cycle compare of all three instances against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 3; i++) begin
        logic [31:0] r;
        logic s, b, d;
        case (i)
          0:       begin r = 32'(rout6);  s = sout6;  b = busy6;  d = done6;  end
          1:       begin r = 32'(rout2);  s = sout2;  b = busy2;  d = done2;  end
          default: begin r = 32'(rout16); s = sout16; b = busy16; d = done16; end
        endcase
        chk($sformatf("w%0d_rout", wd[i]), r, m_reg[i]);
        chk($sformatf("w%0d_sout", wd[i]), 32'(s),
            m_dir[i] ? ((m_reg[i] >> (wd[i] - 1)) & 1) : (m_reg[i] & 1));
        chk($sformatf("w%0d_busy", wd[i]), 32'(b), 32'(m_cnt[i] != 0));
        chk($sformatf("w%0d_done", wd[i]), 32'(d), 32'(m_done[i]));
      end
    end
  end

  task automatic cyc(input bit e, input logic [1:0] m, input bit s, input bit r);
    @(negedge clk);
    en = e; mode = m; sin = s; rot = r;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [1:0] b, input logic [15:0] c);
    @(negedge clk);
    rin6 = a; rin2 = b; rin16 = c;
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
  endtask

  int first_done[3];
  int piso_seq[6] = '{1, 0, 1, 1, 0, 1};
  int sipo_bits[6] = '{1, 1, 0, 0, 1, 0};
  logic [5:0] saved6;

  initial begin
    #12;
    chk("reset_rout", 32'(rout6), 32'h0);
    chk("reset_busy", 32'(busy6), 32'h0);
    chk("reset_done", 32'(done6), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cmp_on = 1'b1;

    // Asynchronous reset in the middle of a transfer
    load(6'h2A, 2'b10, 16'h002A);
    chk("pre_reset_rout", 32'(rout6), 32'h2A);
    chk("pre_reset_busy", 32'(busy6), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async_rout", 32'(rout6), 32'h0);
    chk("async_busy", 32'(busy6), 32'h0);
    chk("async_done", 32'(done6), 32'h0);
    chk("async_sout", 32'(sout6), 32'h0);
    chk("async_rout16", 32'(rout16), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // PISO: done must land after exactly WIDTH shifts for each width
    load(6'b101101, 2'b01, 16'hB52D);
    first_done = '{0, 0, 0};
    for (int k = 1; k <= 16; k++) begin
      if (k <= 6) chk($sformatf("piso_sout_%0d", k), 32'(sout6), 32'(piso_seq[k-1]));
      cyc(1'b1, 2'b01, 1'b0, 1'b0);
      if (done6  && first_done[0] == 0) first_done[0] = k;
      if (done2  && first_done[1] == 0) first_done[1] = k;
      if (done16 && first_done[2] == 0) first_done[2] = k;
    end
    chk("piso_done_w6", 32'(first_done[0]), 32'd6);
    chk("piso_done_w2", 32'(first_done[1]), 32'd2);
    chk("piso_done_w16", 32'(first_done[2]), 32'd16);
    chk("piso_rout_end", 32'(rout6), 32'h0);

    // SIPO from an idle counter
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 2'b10, sipo_bits[k][0], 1'b0);
      chk("sipo_done", 32'(done6), 32'h0);
      chk("sipo_busy", 32'(busy6), 32'h0);
    end
    chk("sipo_rout_w6", 32'(rout6), 32'b110010);
    chk("sipo_rout_w2", 32'(rout2), 32'b10);
    chk("sipo_rout_w16", 32'(rout16), 32'h0032);
    chk("sipo_sout_w6", 32'(sout6), 32'h1);

    // A load keeps the last shift direction for SOUT
    load(6'h1F, 2'b01, 16'h7FFF);
    chk("load_keeps_dir", 32'(sout6), 32'h0);
    chk("load_busy", 32'(busy6), 32'h1);

    // Reload mid-transfer, then enable gating
    load(6'h3F, 2'b11, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 2'b01, 1'b0, 1'b0);
      chk("aborted_no_done", 32'(done6), 32'h0);
    end
    load(6'h05, 2'b01, 16'h0005);
    chk("reload_busy", 32'(busy6), 32'h1);
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    chk("w2_done_pulse", 32'(done2), 32'h1);
    saved6 = rout6;
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 2'b01, 1'b1, 1'b0);
      chk("en0_rout", 32'(rout6), 32'(saved6));
      chk("en0_busy", 32'(busy6), 32'h1);
      chk("en0_clears_done", 32'(done2), 32'h0);
    end
    cyc(1'b1, 2'b00, 1'b1, 1'b0);
    chk("hold_rout", 32'(rout6), 32'(saved6));
    for (int j = 3; j <= 6; j++) begin
      cyc(1'b1, 2'b01, 1'b0, 1'b0);
      chk($sformatf("reload_done_%0d", j), 32'(done6), 32'(j == 6));
    end
    chk("reload_rout_end", 32'(rout6), 32'h0);

    // Rotate request: recirculates only when the feature is built in
    load(6'b000001, 2'b01, 16'h0001);
    cyc(1'b1, 2'b01, 1'b0, 1'b1);
    chk("rot_first", 32'(rout6), ROT ? 32'b100000 : 32'h0);
    for (int k = 2; k <= 6; k++) cyc(1'b1, 2'b01, 1'b0, 1'b1);
    chk("rot_final", 32'(rout6), ROT ? 32'b000001 : 32'h0);
    chk("rot_done", 32'(done6), 32'h1);

    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
